// File: rtl/i2c_eeprom_slave_if.sv
// I2C EEPROM slave bus bundle.
// Signals:
//   scl    - I2C clock as seen at the pad (asynchronous to clk)
//   sda_in - I2C data as read at the pad (asynchronous to clk)
//   sda_oe - 1 = slave pulls sda low, 0 = slave releases sda
//   wp     - write protect level
//   busy   - internal write cycle in progress
interface i2c_eeprom_slave_if;
    logic scl;
    logic sda_in;
    logic sda_oe;
    logic wp;
    logic busy;

    modport slave (
        input  scl,
        input  sda_in,
        input  wp,
        output sda_oe,
        output busy
    );

    modport master (
        output scl,
        output sda_in,
        output wp,
        input  sda_oe,
        input  busy
    );
endinterface

// File: rtl/i2c_eeprom_slave.sv
// I2C serial EEPROM slave, oversampled by clk.
// Byte/page write with in-page wrap, current/random/sequential read,
// write protect and a post-STOP write-cycle busy window.
// Ports:
//   clk - system clock (>= 16x scl frequency)
//   rst - synchronous active-high reset
//   bus - i2c_eeprom_slave_if.slave: scl, sda_in, wp in; sda_oe, busy out
module i2c_eeprom_slave #(
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned DEPTH     = 2048,
    parameter int unsigned PAGE_SIZE = 16,
    parameter logic [3:0]  DEV_TYPE  = 4'b1010,
    parameter int unsigned T_WR      = 1000
) (
    input  logic              clk,
    input  logic              rst,
    i2c_eeprom_slave_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(T_WR + 1);
    localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'(8'hFF);
    localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(PAGE_SIZE - 1);

    typedef enum logic [3:0] {
        IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    state_t            state;
    logic [1:0]        scl_sync;
    logic [1:0]        sda_sync;
    logic              scl_q;
    logic              sda_q;
    logic              scl_rise_c;
    logic              scl_fall_c;
    logic              start_c;
    logic              stop_c;
    logic [3:0]        bit_cnt;
    logic [7:0]        shift;
    logic [7:0]        rbyte;
    logic [ADDR_W-1:0] ptr;
    logic              rw;
    logic              mack;
    logic              write_pending;
    logic              sda_drive;
    logic              busy_reg;
    logic [CNT_W-1:0]  busy_cnt;
    logic              mem_we_c;
    logic [7:0]        rd_byte_c;
    logic [7:0]        mem [DEPTH];

    assign bus.sda_oe = sda_drive;
    assign bus.busy   = busy_reg;

    // Two-flop synchronisers plus one edge-detect stage; idle bus is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl};
            sda_sync <= {sda_sync[0], bus.sda_in};
            scl_q    <= scl_sync[1];
            sda_q    <= sda_sync[1];
        end
    end

    // Bus events; START/STOP require scl stable high across both samples.
    always_comb begin
        scl_rise_c = scl_sync[1] & ~scl_q;
        scl_fall_c = ~scl_sync[1] & scl_q;
        start_c    = scl_sync[1] & scl_q & sda_q & ~sda_sync[1];
        stop_c     = scl_sync[1] & scl_q & ~sda_q & sda_sync[1];
    end

    // Write lands in the cycle the data ACK slot opens.
    always_comb begin
        mem_we_c  = ~rst && (state == WDATA) && scl_fall_c && (bit_cnt == 4'd8) && ~bus.wp;
        rd_byte_c = mem[ptr];
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[ptr] <= shift;
        end
    end

    // Protocol FSM; sda_drive only moves on a synchronised scl fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sda_drive     <= 1'b0;
            busy_reg      <= 1'b0;
            busy_cnt      <= '0;
            ptr           <= '0;
            write_pending <= 1'b0;
            bit_cnt       <= 4'd0;
            shift         <= 8'd0;
            rbyte         <= 8'd0;
            rw            <= 1'b0;
            mack          <= 1'b1;
        end else begin
            if (busy_reg) begin
                if (busy_cnt == CNT_W'(1)) begin
                    busy_reg <= 1'b0;
                    busy_cnt <= '0;
                end else begin
                    busy_cnt <= busy_cnt - CNT_W'(1);
                end
            end

            if (stop_c) begin
                state   <= IDLE;
                bit_cnt <= 4'd0;
                if (write_pending) begin
                    write_pending <= 1'b0;
                    busy_reg      <= 1'b1;
                    busy_cnt      <= CNT_W'(T_WR);
                end
            end else if (start_c) begin
                // Repeated START drops any partial byte but keeps the pointer.
                state   <= CTRL;
                bit_cnt <= 4'd0;
            end else begin
                if (scl_rise_c) begin
                    if ((state == CTRL || state == ADDR || state == WDATA) && bit_cnt != 4'd8) begin
                        shift   <= {shift[6:0], sda_sync[1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    if (state == RDATA && bit_cnt != 4'd8) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    if (state == RDATA_ACK) begin
                        mack <= sda_sync[1];
                    end
                end

                if (scl_fall_c) begin
                    case (state)
                        CTRL: begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= 4'd0;
                                if (shift[7:4] == DEV_TYPE && !busy_reg) begin
                                    sda_drive <= 1'b1;
                                    rw        <= shift[0];
                                    state     <= CTRL_ACK;
                                    // Control bits [3:1] supply the address bits above bit 7.
                                    if (!shift[0]) begin
                                        ptr <= (ptr & LOW_MASK) |
                                               ((ADDR_W'(shift[3:1]) << 8) & ~LOW_MASK);
                                    end
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end
                        CTRL_ACK: begin
                            bit_cnt <= 4'd0;
                            if (rw) begin
                                rbyte     <= rd_byte_c;
                                sda_drive <= ~rd_byte_c[7];
                                ptr       <= ptr + ADDR_W'(1);
                                state     <= RDATA;
                            end else begin
                                sda_drive <= 1'b0;
                                state     <= ADDR;
                            end
                        end
                        ADDR: begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt   <= 4'd0;
                                ptr       <= (ptr & ~LOW_MASK) | ADDR_W'(shift);
                                sda_drive <= 1'b1;
                                state     <= ADDR_ACK;
                            end
                        end
                        ADDR_ACK: begin
                            sda_drive <= 1'b0;
                            state     <= WDATA;
                        end
                        WDATA: begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= 4'd0;
                                state   <= WDATA_ACK;
                                if (!bus.wp) begin
                                    sda_drive     <= 1'b1;
                                    write_pending <= 1'b1;
                                    // Only the in-page offset advances.
                                    ptr <= (ptr & ~PAGE_MASK) | ((ptr + ADDR_W'(1)) & PAGE_MASK);
                                end
                            end
                        end
                        WDATA_ACK: begin
                            sda_drive <= 1'b0;
                            state     <= WDATA;
                        end
                        RDATA: begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt   <= 4'd0;
                                sda_drive <= 1'b0;
                                mack      <= 1'b1;
                                state     <= RDATA_ACK;
                            end else begin
                                rbyte     <= {rbyte[6:0], 1'b0};
                                sda_drive <= ~rbyte[6];
                            end
                        end
                        RDATA_ACK: begin
                            if (!mack) begin
                                rbyte     <= rd_byte_c;
                                sda_drive <= ~rd_byte_c[7];
                                ptr       <= ptr + ADDR_W'(1);
                                state     <= RDATA;
                            end else begin
                                sda_drive <= 1'b0;
                                state     <= IDLE;
                            end
                        end
                        IDLE: begin
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Scoreboard bench for i2c_eeprom_slave: a bit-banged I2C master drives the
// bus, expected values are queued as stimulus is issued and a monitor pops
// and compares them as the DUT presents ACK bits, read bytes and busy windows.
module tb_i2c_eeprom_slave;

    localparam int unsigned T_WR = 300;
    localparam int Q = 50;

    typedef struct {
        string name;
        int    val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic scl_m;
    logic sda_m;
    logic wp_m;
    logic watch;
    logic oe_seen;

    exp_t exp_q[$];
    int   obs_q[$];
    int   exp_busy_q[$];
    int   obs_busy_q[$];
    int   checks = 0;
    int   errors = 0;

    i2c_eeprom_slave_if bus();

    assign bus.scl    = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;
    assign bus.wp     = wp_m;

    i2c_eeprom_slave #(.T_WR(T_WR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void expect_val(input string name, input int v);
        exp_t e;
        e.name = name;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    function automatic void chk(input string name, input int e, input int a);
        expect_val(name, e);
        obs_q.push_back(a);
    endfunction

    // Monitor: compare every presented output against the expectation queue.
    initial begin
        exp_t e;
        int   a;
        forever begin
            @(negedge clk);
            while (obs_q.size() > 0) begin
                a = obs_q.pop_front();
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %0h with nothing expected", a);
                end else begin
                    e = exp_q.pop_front();
                    if (a != e.val) begin
                        errors++;
                        $display("FAIL %s: got %0h expected %0h", e.name, a, e.val);
                    end
                end
            end
            while (obs_busy_q.size() > 0) begin
                a = obs_busy_q.pop_front();
                checks++;
                if (exp_busy_q.size() == 0) begin
                    errors++;
                    $display("FAIL busy_len: unexpected busy window of %0d cycles", a);
                end else begin
                    int eb;
                    eb = exp_busy_q.pop_front();
                    if (a != eb) begin
                        errors++;
                        $display("FAIL busy_len: got %0d cycles expected %0d", a, eb);
                    end
                end
            end
        end
    end

    // Busy window length observer.
    initial begin
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (bus.busy) begin
                run++;
            end else if (run != 0) begin
                obs_busy_q.push_back(run);
                run = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (watch && bus.sda_oe) oe_seen = 1'b1;
        end
    end

    task automatic bit_w(input logic b);
        sda_m = b;
        #Q scl_m = 1'b1;
        #Q;
        #Q scl_m = 1'b0;
        #Q;
    endtask

    task automatic bit_r(output logic b, output logic oe);
        sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q b = bus.sda_in;
        oe = bus.sda_oe;
        #Q scl_m = 1'b0;
        #Q;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b1;
        #Q;
    endtask

    // exp_ack: 1 = slave must drive the ACK slot, 0 = slave must leave it released.
    task automatic wr_byte(input logic [7:0] d, input int exp_ack, input string name);
        logic b;
        logic oe;
        for (int i = 7; i >= 0; i--) bit_w(d[i]);
        expect_val(name, exp_ack);
        bit_r(b, oe);
        obs_q.push_back(int'(oe));
    endtask

    task automatic rd_byte(input logic [7:0] e, input logic m_ack, input string name);
        logic       b;
        logic       oe;
        logic [7:0] d;
        expect_val(name, int'(e));
        d = 8'd0;
        for (int i = 0; i < 8; i++) begin
            bit_r(b, oe);
            d = {d[6:0], b};
        end
        obs_q.push_back(int'(d));
        bit_w(m_ack);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("busy_release", 0, int'(bus.busy));
        repeat (5) @(negedge clk);
    endtask

    task automatic wr_one(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
        i2c_start();
        wr_byte(c, 1, "setup_ctrl_ack");
        wr_byte(a, 1, "setup_addr_ack");
        wr_byte(d, 1, "setup_data_ack");
        exp_busy_q.push_back(T_WR);
        i2c_stop();
        wait_idle();
    endtask

    initial begin
        int          n;
        logic        b;
        logic        oe;
        logic [7:0]  e;
        scl_m   = 1'b1;
        sda_m   = 1'b1;
        wp_m    = 1'b0;
        watch   = 1'b0;
        oe_seen = 1'b0;
        rst     = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_sda_oe", 0, int'(bus.sda_oe));
        chk("reset_busy", 0, int'(bus.busy));
        repeat (10) @(negedge clk);

        // Byte write to 0x123, then random read back.
        i2c_start();
        wr_byte(8'hA2, 1, "t1_ctrl_ack");
        wr_byte(8'h23, 1, "t1_addr_ack");
        wr_byte(8'h5A, 1, "t1_data_ack");
        exp_busy_q.push_back(T_WR);
        i2c_stop();
        wait_idle();
        i2c_start();
        wr_byte(8'hA2, 1, "t1_dummy_ctrl_ack");
        wr_byte(8'h23, 1, "t1_dummy_addr_ack");
        i2c_start();
        wr_byte(8'hA3, 1, "t1_read_ctrl_ack");
        rd_byte(8'h5A, 1'b1, "t1_rdata");
        i2c_stop();

        // Known contents for later tests.
        wr_one(8'hA2, 8'h00, 8'hC3);
        wr_one(8'hA0, 8'h10, 8'h44);
        wr_one(8'hA0, 8'h00, 8'h33);
        wr_one(8'hAE, 8'hFE, 8'h11);
        wr_one(8'hAE, 8'hFF, 8'h22);

        // Page write of 20 bytes from 0x0F0 wraps inside the page.
        i2c_start();
        wr_byte(8'hA0, 1, "pw_ctrl_ack");
        wr_byte(8'hF0, 1, "pw_addr_ack");
        for (int i = 0; i < 20; i++) wr_byte(8'(i), 1, "pw_data_ack");
        exp_busy_q.push_back(T_WR);
        i2c_stop();
        wait_idle();
        i2c_start();
        wr_byte(8'hA0, 1, "pw_rd_ctrl_ack");
        wr_byte(8'hF0, 1, "pw_rd_addr_ack");
        i2c_start();
        wr_byte(8'hA1, 1, "pw_rd_ctrl2_ack");
        for (int k = 0; k < 17; k++) begin
            if (k < 4)       e = 8'(8'h10 + k);
            else if (k < 16) e = 8'(k);
            else             e = 8'hC3;
            rd_byte(e, (k == 16) ? 1'b1 : 1'b0, "pw_rdata");
        end
        i2c_stop();

        // Sequential read wraps from 0x7FF to 0x000.
        i2c_start();
        wr_byte(8'hAE, 1, "sr_ctrl_ack");
        wr_byte(8'hFE, 1, "sr_addr_ack");
        i2c_start();
        wr_byte(8'hA1, 1, "sr_rd_ctrl_ack");
        rd_byte(8'h11, 1'b0, "sr_rdata_7fe");
        rd_byte(8'h22, 1'b0, "sr_rdata_7ff");
        rd_byte(8'h33, 1'b1, "sr_rdata_000");
        chk("sr_release", 0, int'(bus.sda_oe));
        i2c_stop();

        // Wrong device type: NACK and silence on the following clocks.
        i2c_start();
        wr_byte(8'hB0, 0, "wd_ctrl_nack");
        oe_seen = 1'b0;
        watch   = 1'b1;
        for (int i = 0; i < 16; i++) bit_r(b, oe);
        watch = 1'b0;
        chk("wd_quiet", 0, int'(oe_seen));
        i2c_stop();

        // Control byte during the write cycle is refused, accepted afterwards.
        i2c_start();
        wr_byte(8'hA0, 1, "bz_ctrl_ack");
        wr_byte(8'h50, 1, "bz_addr_ack");
        wr_byte(8'h99, 1, "bz_data_ack");
        exp_busy_q.push_back(T_WR);
        i2c_stop();
        i2c_start();
        wr_byte(8'hA0, 0, "bz_ctrl_nack_while_busy");
        i2c_stop();
        wait_idle();
        i2c_start();
        wr_byte(8'hA0, 1, "bz_ctrl_ack_after");
        wr_byte(8'h50, 1, "bz_addr2_ack");
        i2c_start();
        wr_byte(8'hA1, 1, "bz_rd_ctrl_ack");
        rd_byte(8'h99, 1'b1, "bz_rdata");
        i2c_stop();

        // Write protect: data NACKed, no write, no busy window.
        i2c_start();
        wr_byte(8'hA0, 1, "wp_ctrl_ack");
        wr_byte(8'h10, 1, "wp_addr_ack");
        wp_m = 1'b1;
        wr_byte(8'h77, 0, "wp_data_nack");
        i2c_stop();
        wp_m = 1'b0;
        repeat (20) @(negedge clk);
        chk("wp_busy", 0, int'(bus.busy));
        i2c_start();
        wr_byte(8'hA0, 1, "wp_rd_ctrl_ack");
        wr_byte(8'h10, 1, "wp_rd_addr_ack");
        i2c_start();
        wr_byte(8'hA1, 1, "wp_rd_ctrl2_ack");
        rd_byte(8'h44, 1'b1, "wp_rdata");
        i2c_stop();

        // Reset while the slave is driving read data.
        i2c_start();
        wr_byte(8'hA2, 1, "rs_ctrl_ack");
        wr_byte(8'h23, 1, "rs_addr_ack");
        i2c_start();
        wr_byte(8'hA3, 1, "rs_rd_ctrl_ack");
        n = 0;
        while (!bus.sda_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rs_pre_oe", 1, int'(bus.sda_oe));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rs_oe_after_rst", 0, int'(bus.sda_oe));
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        i2c_stop();
        i2c_start();
        wr_byte(8'hA1, 1, "rs_cur_ctrl_ack");
        rd_byte(8'h33, 1'b1, "rs_cur_rdata");
        i2c_stop();

        // Drain the scoreboard; anything still expected is a miss.
        n = 0;
        while ((obs_q.size() > 0 || obs_busy_q.size() > 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: no output observed, expected %0h", x.name, x.val);
        end
        while (exp_busy_q.size() > 0) begin
            int x;
            x = exp_busy_q.pop_front();
            checks++;
            errors++;
            $display("FAIL busy_len: no busy window observed, expected %0d cycles", x);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
